alu_arbiter: RTL and testbench

//  Shares the single execute-stage ALU between two requesters: port 0 (main pipeline

---
 rtl/alu_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Arbiter sharing one combinational execute-stage ALU between two requesters.
// Port 0 is the main pipeline and port 1 a secondary client. Each port has a
// one-entry registered response slot with a valid/ready handshake.
module alu_arbiter #(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned MAX_WAIT    = 8,
  parameter int unsigned CNT_W       = 4,
  // Encoding of ALU_OPERATIONS_NOP driven to the ALU when nothing is granted
  parameter logic [7:0]  AluOpNop    = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [7:0]  req0_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic        req0_is_branch_i,

  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [7:0]  req1_op_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic        req1_is_branch_i,

  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [31:0] rsp0_result_o,
  output logic        rsp0_taken_o,

  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp1_result_o,
  output logic        rsp1_taken_o,

  output logic [7:0]  alu_operation_o,
  output logic [31:0] operand1_o,
  output logic [31:0] operand2_o,
  output logic        is_branch_instruction_o,
  input  logic [31:0] alu_result_i,
  input  logic        branch_taken_i,

  output logic        grant_port_o
);

  localparam logic [CNT_W-1:0] MaxWait = CNT_W'(MAX_WAIT);

  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             rsp0_valid_q, rsp0_valid_d;
  logic [31:0]      rsp0_result_q, rsp0_result_d;
  logic             rsp0_taken_q, rsp0_taken_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [31:0]      rsp1_result_q, rsp1_result_d;
  logic             rsp1_taken_q, rsp1_taken_d;

  logic             slot_free0, slot_free1;
  logic             elig0, elig1;
  logic             grant0, grant1;

  // Eligibility: a slot drained this cycle counts as free; nothing is granted in reset.
  always_comb begin
    slot_free0 = !rsp0_valid_q || rsp0_ready_i;
    slot_free1 = !rsp1_valid_q || rsp1_ready_i;
    elig0      = req0_valid_i && slot_free0 && !rst_i;
    elig1      = req1_valid_i && slot_free1 && !rst_i;
  end

  // Grant selection: at most one port per cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      if (ROUND_ROBIN) begin
        if (ptr_q) grant1 = 1'b1;
        else       grant0 = 1'b1;
      end else if (cnt_q == MaxWait) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b1;
      end
    end else if (elig0) begin
      grant0 = 1'b1;
    end else if (elig1) begin
      grant1 = 1'b1;
    end
  end

  // Priority pointer and starvation counter next state.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (grant0)      ptr_d = 1'b1;
    else if (grant1) ptr_d = 1'b0;
    if (ROUND_ROBIN) begin
      cnt_d = '0;
    end else if (grant1) begin
      cnt_d = '0;
    end else if (elig1 && (cnt_q != MaxWait)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ALU input mux and handshake outputs.
  always_comb begin
    alu_operation_o         = AluOpNop;
    operand1_o              = '0;
    operand2_o              = '0;
    is_branch_instruction_o = 1'b0;
    if (grant0) begin
      alu_operation_o         = req0_op_i;
      operand1_o              = req0_a_i;
      operand2_o              = req0_b_i;
      is_branch_instruction_o = req0_is_branch_i;
    end else if (grant1) begin
      alu_operation_o         = req1_op_i;
      operand1_o              = req1_a_i;
      operand2_o              = req1_b_i;
      is_branch_instruction_o = req1_is_branch_i;
    end
    req0_ready_o = grant0;
    req1_ready_o = grant1;
    grant_port_o = grant1;
  end

  // Response slots: load on grant, clear valid on drain, otherwise hold.
  always_comb begin
    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_taken_d  = rsp0_taken_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_taken_d  = rsp1_taken_q;
    if (grant0) begin
      rsp0_valid_d  = 1'b1;
      rsp0_result_d = alu_result_i;
      rsp0_taken_d  = branch_taken_i;
    end else if (rsp0_ready_i) begin
      rsp0_valid_d = 1'b0;
    end
    if (grant1) begin
      rsp1_valid_d  = 1'b1;
      rsp1_result_d = alu_result_i;
      rsp1_taken_d  = branch_taken_i;
    end else if (rsp1_ready_i) begin
      rsp1_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset discards any result in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q         <= 1'b0;
      cnt_q         <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_taken_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_taken_q  <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_taken_q  <= rsp0_taken_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_taken_q  <= rsp1_taken_d;
    end
  end

  assign rsp0_valid_o  = rsp0_valid_q;
  assign rsp0_result_o = rsp0_result_q;
  assign rsp0_taken_o  = rsp0_taken_q;
  assign rsp1_valid_o  = rsp1_valid_q;
  assign rsp1_result_o = rsp1_result_q;
  assign rsp1_taken_o  = rsp1_taken_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance with a response scoreboard and a
// fixed-priority instance (MAX_WAIT=3) for the starvation-counter pattern.
module tb_alu_arbiter;

  localparam logic [7:0] OpNop = 8'h00;
  localparam logic [7:0] OpAdd = 8'h01;
  localparam logic [7:0] OpSub = 8'h02;
  localparam logic [7:0] OpBeq = 8'h10;
  localparam logic [7:0] OpBne = 8'h11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // External ALU model: {taken, result}
  function automatic logic [32:0] alu_model(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] r;
    r = '0;
    case (op)
      OpAdd:   r[31:0] = a + b;
      OpSub:   r[31:0] = a - b;
      OpBeq:   r[32]   = (a == b);
      OpBne:   r[32]   = (a != b);
      default: r       = '0;
    endcase
    return r;
  endfunction

  // Round-robin instance signals
  logic        r_rst, r_req0_valid, r_req0_ready, r_req0_br, r_req1_valid, r_req1_ready, r_req1_br;
  logic [7:0]  r_req0_op, r_req1_op, r_alu_op;
  logic [31:0] r_req0_a, r_req0_b, r_req1_a, r_req1_b, r_opa, r_opb, r_alu_res;
  logic        r_rsp0_valid, r_rsp0_ready, r_rsp0_taken, r_rsp1_valid, r_rsp1_ready, r_rsp1_taken;
  logic [31:0] r_rsp0_result, r_rsp1_result;
  logic        r_is_br, r_alu_taken, r_grant;

  // Fixed-priority instance signals
  logic        f_rst, f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
  logic [7:0]  f_alu_op;
  logic [31:0] f_opa, f_opb, f_alu_res, f_rsp0_result, f_rsp1_result;
  logic        f_rsp0_valid, f_rsp1_valid, f_rsp0_taken, f_rsp1_taken, f_is_br, f_alu_taken;
  logic        f_grant, f_rsp_ready;

  always_comb {r_alu_taken, r_alu_res} = alu_model(r_alu_op, r_opa, r_opb);
  always_comb {f_alu_taken, f_alu_res} = alu_model(f_alu_op, f_opa, f_opb);

  alu_arbiter #(.ROUND_ROBIN(1'b1), .MAX_WAIT(8), .CNT_W(4)) u_rr (
    .clk_i(clk), .rst_i(r_rst),
    .req0_valid_i(r_req0_valid), .req0_ready_o(r_req0_ready), .req0_op_i(r_req0_op),
    .req0_a_i(r_req0_a), .req0_b_i(r_req0_b), .req0_is_branch_i(r_req0_br),
    .req1_valid_i(r_req1_valid), .req1_ready_o(r_req1_ready), .req1_op_i(r_req1_op),
    .req1_a_i(r_req1_a), .req1_b_i(r_req1_b), .req1_is_branch_i(r_req1_br),
    .rsp0_valid_o(r_rsp0_valid), .rsp0_ready_i(r_rsp0_ready), .rsp0_result_o(r_rsp0_result),
    .rsp0_taken_o(r_rsp0_taken),
    .rsp1_valid_o(r_rsp1_valid), .rsp1_ready_i(r_rsp1_ready), .rsp1_result_o(r_rsp1_result),
    .rsp1_taken_o(r_rsp1_taken),
    .alu_operation_o(r_alu_op), .operand1_o(r_opa), .operand2_o(r_opb),
    .is_branch_instruction_o(r_is_br), .alu_result_i(r_alu_res), .branch_taken_i(r_alu_taken),
    .grant_port_o(r_grant)
  );

  alu_arbiter #(.ROUND_ROBIN(1'b0), .MAX_WAIT(3), .CNT_W(4)) u_fp (
    .clk_i(clk), .rst_i(f_rst),
    .req0_valid_i(f_req0_valid), .req0_ready_o(f_req0_ready), .req0_op_i(OpAdd),
    .req0_a_i(32'd1), .req0_b_i(32'd2), .req0_is_branch_i(1'b0),
    .req1_valid_i(f_req1_valid), .req1_ready_o(f_req1_ready), .req1_op_i(OpSub),
    .req1_a_i(32'd9), .req1_b_i(32'd4), .req1_is_branch_i(1'b0),
    .rsp0_valid_o(f_rsp0_valid), .rsp0_ready_i(f_rsp_ready), .rsp0_result_o(f_rsp0_result),
    .rsp0_taken_o(f_rsp0_taken),
    .rsp1_valid_o(f_rsp1_valid), .rsp1_ready_i(f_rsp_ready), .rsp1_result_o(f_rsp1_result),
    .rsp1_taken_o(f_rsp1_taken),
    .alu_operation_o(f_alu_op), .operand1_o(f_opa), .operand2_o(f_opb),
    .is_branch_instruction_o(f_is_br), .alu_result_i(f_alu_res), .branch_taken_i(f_alu_taken),
    .grant_port_o(f_grant)
  );

  // Scoreboard for the round-robin instance: {taken, result}
  logic [32:0] exp0, exp1;
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  always @(negedge clk) begin
    logic [32:0] e;
    if (r_rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (r_rsp0_valid && r_rsp0_ready) begin
        n_total++;
        if (q0.size() == 0) begin
          $display("FAIL sb_rsp0_unexpected got %0h want none", {r_rsp0_taken, r_rsp0_result});
        end else begin
          e = q0.pop_front();
          if ({r_rsp0_taken, r_rsp0_result} !== e)
            $display("FAIL sb_rsp0 got %0h want %0h", {r_rsp0_taken, r_rsp0_result}, e);
          else n_pass++;
        end
      end
      if (r_rsp1_valid && r_rsp1_ready) begin
        n_total++;
        if (q1.size() == 0) begin
          $display("FAIL sb_rsp1_unexpected got %0h want none", {r_rsp1_taken, r_rsp1_result});
        end else begin
          e = q1.pop_front();
          if ({r_rsp1_taken, r_rsp1_result} !== e)
            $display("FAIL sb_rsp1 got %0h want %0h", {r_rsp1_taken, r_rsp1_result}, e);
          else n_pass++;
        end
      end
      if (r_req0_valid && r_req0_ready) q0.push_back(exp0);
      if (r_req1_valid && r_req1_ready) q1.push_back(exp1);
    end
  end

  task automatic test_reset();
    r_rst = 1'b1; f_rst = 1'b1;
    r_req0_valid = 1'b1; r_req0_op = OpAdd; r_req0_a = 32'd1; r_req0_b = 32'd2;
    r_req1_valid = 1'b1; r_req1_op = OpSub; r_req1_a = 32'd8; r_req1_b = 32'd3;
    repeat (2) begin
      @(posedge clk); #1;
      n_total++;
      if ({r_rsp0_valid, r_rsp1_valid} !== 2'b00)
        $display("FAIL reset_rsp_valid got %b want 00", {r_rsp0_valid, r_rsp1_valid});
      else n_pass++;
      n_total++;
      if ({r_rsp0_taken, r_rsp0_result, r_rsp1_taken, r_rsp1_result} !== 66'd0)
        $display("FAIL reset_rsp_data got %0h/%0h want 0/0", r_rsp0_result, r_rsp1_result);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({r_req0_ready, r_req1_ready} !== 2'b00)
        $display("FAIL reset_ready got %b want 00", {r_req0_ready, r_req1_ready});
      else n_pass++;
      n_total++;
      if (r_alu_op !== OpNop || r_opa !== 32'd0 || r_is_br !== 1'b0)
        $display("FAIL reset_alu_op got %0h want %0h", r_alu_op, OpNop);
      else n_pass++;
    end
    @(posedge clk); #1;
    r_rst = 1'b0; f_rst = 1'b0;
    r_req0_valid = 1'b0; r_req1_valid = 1'b0;
  endtask

  task automatic test_single();
    r_req0_valid = 1'b1; r_req0_op = OpAdd; r_req0_a = 32'd5; r_req0_b = 32'd7; r_req0_br = 1'b0;
    exp0 = {1'b0, 32'd12};
    @(negedge clk);
    n_total++;
    if (r_req0_ready !== 1'b1 || r_grant !== 1'b0)
      $display("FAIL single_ready got %b/%b want 1/0", r_req0_ready, r_grant);
    else n_pass++;
    n_total++;
    if (r_alu_op !== OpAdd || r_opa !== 32'd5 || r_opb !== 32'd7)
      $display("FAIL single_alu_in got %0h %0d %0d want 1 5 7", r_alu_op, r_opa, r_opb);
    else n_pass++;
    @(posedge clk); #1;
    r_req0_valid = 1'b0;
    n_total++;
    if (r_rsp0_valid !== 1'b1 || r_rsp0_result !== 32'd12)
      $display("FAIL single_rsp got %b/%0d want 1/12", r_rsp0_valid, r_rsp0_result);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (r_rsp0_valid !== 1'b0)
      $display("FAIL single_drain got %b want 0", r_rsp0_valid);
    else n_pass++;
  endtask

  task automatic test_rr_contention();
    logic [31:0] a0, b0, a1, b1;
    r_rst = 1'b1;
    @(posedge clk); #1;
    r_rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      r_req0_valid = 1'b1; r_req0_op = OpSub; r_req0_a = a0; r_req0_b = b0;
      r_req1_valid = 1'b1; r_req1_op = OpAdd; r_req1_a = a1; r_req1_b = b1; r_req1_br = 1'b0;
      exp0 = {1'b0, a0 - b0};
      exp1 = {1'b0, a1 + b1};
      @(negedge clk);
      n_total++;
      if (r_grant !== c[0] || r_req0_ready !== !c[0] || r_req1_ready !== c[0])
        $display("FAIL rr_grant_c%0d got %b%b%b want %b%b%b", c, r_grant, r_req0_ready,
                 r_req1_ready, c[0], !c[0], c[0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    r_req0_valid = 1'b0; r_req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_prio();
    logic want;
    f_rst = 1'b1;
    @(posedge clk); #1;
    f_rst = 1'b0;
    f_req0_valid = 1'b1; f_req1_valid = 1'b1; f_rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      want = ((c % 4) == 3);
      @(negedge clk);
      n_total++;
      if (f_grant !== want || f_req1_ready !== want || f_req0_ready !== !want)
        $display("FAIL fixed_grant_c%0d got %b%b%b want %b%b%b", c, f_grant, f_req0_ready,
                 f_req1_ready, want, !want, want);
      else n_pass++;
      @(posedge clk); #1;
    end
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    r_rsp0_ready = 1'b0;
    r_req0_valid = 1'b1; r_req0_op = OpAdd; r_req0_a = 32'd5; r_req0_b = 32'd7;
    exp0 = {1'b0, 32'd12};
    @(negedge clk);
    n_total++;
    if (r_req0_ready !== 1'b1) $display("FAIL bp_fill got %b want 1", r_req0_ready);
    else n_pass++;
    @(posedge clk); #1;
    r_req0_op = OpSub; r_req0_a = 32'd9; r_req0_b = 32'd4;
    exp0 = {1'b0, 32'd5};
    r_req1_valid = 1'b1; r_req1_op = OpAdd; r_req1_a = 32'd1; r_req1_b = 32'd2;
    exp1 = {1'b0, 32'd3};
    repeat (3) begin
      @(negedge clk);
      n_total++;
      if (r_req0_ready !== 1'b0 || r_req1_ready !== 1'b1)
        $display("FAIL bp_blocked got %b%b want 01", r_req0_ready, r_req1_ready);
      else n_pass++;
      n_total++;
      if (r_rsp0_valid !== 1'b1 || r_rsp0_result !== 32'd12)
        $display("FAIL bp_hold got %b/%0d want 1/12", r_rsp0_valid, r_rsp0_result);
      else n_pass++;
      @(posedge clk); #1;
    end
    r_req1_valid = 1'b0;
    r_rsp0_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (r_req0_ready !== 1'b1) $display("FAIL bp_same_cycle got %b want 1", r_req0_ready);
    else n_pass++;
    @(posedge clk); #1;
    r_req0_valid = 1'b0;
    n_total++;
    if (r_rsp0_valid !== 1'b1 || r_rsp0_result !== 32'd5)
      $display("FAIL bp_reload got %b/%0d want 1/5", r_rsp0_valid, r_rsp0_result);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (r_rsp0_valid !== 1'b0 || r_rsp0_result !== 32'd5)
      $display("FAIL bp_drain_keep got %b/%0d want 0/5", r_rsp0_valid, r_rsp0_result);
    else n_pass++;
  endtask

  task automatic test_branch();
    r_rsp1_ready = 1'b1;
    r_req1_valid = 1'b1; r_req1_op = OpBeq; r_req1_a = 32'd3; r_req1_b = 32'd3; r_req1_br = 1'b1;
    exp1 = {1'b1, 32'd0};
    @(negedge clk);
    n_total++;
    if (r_req1_ready !== 1'b1 || r_grant !== 1'b1 || r_is_br !== 1'b1 || r_alu_op !== OpBeq)
      $display("FAIL br_issue got %b%b%b/%0h want 111/%0h", r_req1_ready, r_grant, r_is_br,
               r_alu_op, OpBeq);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (r_rsp1_valid !== 1'b1 || r_rsp1_taken !== 1'b1)
      $display("FAIL br_beq got %b/%b want 1/1", r_rsp1_valid, r_rsp1_taken);
    else n_pass++;
    r_req1_op = OpBne;
    exp1 = {1'b0, 32'd0};
    @(posedge clk); #1;
    n_total++;
    if (r_rsp1_valid !== 1'b1 || r_rsp1_taken !== 1'b0)
      $display("FAIL br_bne got %b/%b want 1/0", r_rsp1_valid, r_rsp1_taken);
    else n_pass++;
    // Reset in the would-be accept cycle: the BEQ must not land in the slot
    r_req1_op = OpBeq;
    r_rst = 1'b1;
    @(posedge clk); #1;
    r_rst = 1'b0;
    r_req1_valid = 1'b0; r_req1_br = 1'b0;
    n_total++;
    if (r_rsp1_valid !== 1'b0 || r_rsp1_taken !== 1'b0)
      $display("FAIL br_reset_abort got %b/%b want 0/0", r_rsp1_valid, r_rsp1_taken);
    else n_pass++;
  endtask

  task automatic test_drain();
    int waited;
    waited = 0;
    while ((q0.size() != 0 || q1.size() != 0) && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    n_total++;
    if (q0.size() != 0 || q1.size() != 0)
      $display("FAIL sb_leftover got %0d/%0d want 0/0", q0.size(), q1.size());
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    r_rst = 1'b1; f_rst = 1'b1;
    r_req0_valid = 1'b0; r_req0_op = OpNop; r_req0_a = '0; r_req0_b = '0; r_req0_br = 1'b0;
    r_req1_valid = 1'b0; r_req1_op = OpNop; r_req1_a = '0; r_req1_b = '0; r_req1_br = 1'b0;
    r_rsp0_ready = 1'b1; r_rsp1_ready = 1'b1;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0; f_rsp_ready = 1'b1;
    exp0 = '0; exp1 = '0;
    test_reset();
    test_single();
    test_rr_contention();
    test_fixed_prio();
    test_backpressure();
    test_branch();
    test_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
